lcd_stream_out: RTL and testbench
=================================

# lcd_stream_out

Parametrised successor to the LCD interface top. Accepts an AXI4-Stream pixel stream, buffers it in an internal FIFO and drives a parallel RGB LCD with generated hsync/vsync/enable, free-running timing and configurable sync polarity. Frame-locks the stream to the display timing on tuser (start of frame), and recovers automatically from underflow. Sits between the video DMA/AXIS source and the LCD pins.

## Interface
- H_PIXEL_COUNT, 8, active pixels per line
- V_PIXEL_COUNT, 4, active lines per frame
- THP_COUNT / THB_COUNT / THF_COUNT, 2 / 3 / 4, hsync pulse, back porch, front porch (clocks)
- TVP_COUNT / TVB_COUNT / TVF_COUNT, 5 / 6 / 7, vsync pulse, back porch, front porch (lines)
- DATA_WIDTH, 18, pixel width
- FIFO_DEPTH, 128, FIFO entries, power of two, >= 4
- PREFILL, 8, minimum FIFO level for lock, 1..FIFO_DEPTH
- HSYNC_POL / VSYNC_POL, 0 / 0, active level of sync outputs
- aclk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- s_axis_tdata  in  DATA_WIDTH  pixel
- s_axis_tvalid  in  1  beat valid
- s_axis_tready  out  1  beat accepted when tvalid&tready
- s_axis_tlast  in  1  last pixel of line
- s_axis_tuser  in  1  first pixel of frame
- clr_i  in  1  clears sticky flags
- hsync_o / vsync_o  out  1  sync pulses, level per *_POL
- enable_o  out  1  data enable
- lcd_dat_o  out  DATA_WIDTH  pixel data
- locked_o  out  1  FSM in RUN
- underflow_o / line_err_o  out  1  sticky flags
- frame_cnt_o  out  16  frames output while locked, wraps

## Operation
- HTOTAL = THP+THB+H+THF, VTOTAL = TVP+TVB+V+TVF. h_cnt 0..HTOTAL-1, v_cnt increments on h wrap, 0..VTOTAL-1. Counters free-run from reset, independent of stream.
- hsync active when h_cnt < THP; vsync active when v_cnt < TVP; active = THP+THB <= h_cnt < THP+THB+H and TVP+TVB <= v_cnt < TVP+TVB+V.
- FIFO stores {tlast, tuser, tdata}; write when tvalid&tready.
- FSM SEEK: tready=1; beats with tuser=0 dropped; beat with tuser=1 written, -> FILL.
- FILL: tready=!full. On last cycle of frame (h=HTOTAL-1, v=VTOTAL-1) with level >= PREFILL -> RUN; else stay.
- RUN: tready=!full. Pop on every active cycle. Popped beat with tuser=1 at non-first pixel, or active cycle with FIFO empty: underflow_o<=1, lcd_dat_o<=0 for that pixel, FIFO flushed, -> SEEK. Popped tlast != (last pixel of line): line_err_o<=1, no resync.
- frame_cnt_o increments at end of each frame completed in RUN without underflow.
- clr_i clears flags; same-cycle set wins over clear.
- Simultaneous push and pop at full: pop frees slot, push accepted same cycle is not allowed (tready uses registered full).

## Timing
- Reset: h_cnt=v_cnt=0, FSM=SEEK, FIFO empty, tready=0 while rst_ni=0, hsync_o=!HSYNC_POL, vsync_o=!VSYNC_POL, enable_o=0, lcd_dat_o=0, locked_o=0, flags=0, frame_cnt_o=0.
- All outputs registered; hsync/vsync/enable/lcd_dat_o delayed exactly 1 clock after counter decode; all four aligned.
- First active pixel after lock: h=THP+THB, v=TVP+TVB of the frame following FILL->RUN; enable_o rises one clock later.
- Reset mid-frame: all state returns to reset values on next edge; in-flight FIFO data discarded.

## Configuration
- LCD_TEST_PATTERN_EN: when defined, adds input tpg_i (1 bit); with tpg_i=1, lcd_dat_o during enable shows 8 vertical colour bars (bar = h_pixel*8/H, value = {3 bits of bar index replicated}), FIFO not popped, FSM held in SEEK. Undefined: no tpg_i port, no pattern logic.

## Test plan
- Defaults (HTOTAL=17, VTOTAL=22), no stream -> hsync period 17, low for 2 clocks; vsync low 5*17=85 clocks per 374; enable_o=0; locked_o=0.
- Send 32 pixels tuser on first, tlast every 8th, continuous -> locked_o rises at frame end, enable_o 8-clock bursts on lines 11..14 carrying pixels 0..31 in order, frame_cnt_o=1 after that frame.
- Pixels before first tuser (5 junk beats) -> junk dropped, output unchanged vs previous test.
- Stop stream after 20 pixels -> pixel 21 outputs 0, underflow_o=1, locked_o=0 next clock, relock on next full frame; clr_i clears underflow_o.
- tlast on pixel 6 instead of 7 -> line_err_o=1, locked_o stays 1.
- rst_ni low for 1 clock mid-line -> all outputs at reset values next clock, h_cnt restarts at 0.

Source files
------------

// File: rtl/lcd_stream_out.sv
// lcd_stream_out: AXI4-Stream pixels -> internal FIFO -> parallel RGB LCD with generated hsync/vsync/enable.
// Latency: sync/enable/data registered 1 clock after raster decode; lock needs PREFILL beats by a frame end.
// Backpressure: tready=1 in SEEK, !full (registered pointers) in FILL/RUN, 0 in reset; underflow flushes and reseeks.
// Optional feature macro: LCD_TEST_PATTERN_EN adds tpg_i and an 8-bar vertical colour test pattern.
module lcd_stream_out #(
  parameter int H_PIXEL_COUNT = 8,
  parameter int V_PIXEL_COUNT = 4,
  parameter int THP_COUNT     = 2,
  parameter int THB_COUNT     = 3,
  parameter int THF_COUNT     = 4,
  parameter int TVP_COUNT     = 5,
  parameter int TVB_COUNT     = 6,
  parameter int TVF_COUNT     = 7,
  parameter int DATA_WIDTH    = 18,
  parameter int FIFO_DEPTH    = 128,
  parameter int PREFILL       = 8,
  parameter bit HSYNC_POL     = 1'b0,
  parameter bit VSYNC_POL     = 1'b0
) (
  input  logic                  aclk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  input  logic                  clr_i,
`ifdef LCD_TEST_PATTERN_EN
  input  logic                  tpg_i,
`endif
  output logic                  hsync_o,
  output logic                  vsync_o,
  output logic                  enable_o,
  output logic [DATA_WIDTH-1:0] lcd_dat_o,
  output logic                  locked_o,
  output logic                  underflow_o,
  output logic                  line_err_o,
  output logic [15:0]           frame_cnt_o
);

  localparam int HTOTAL = THP_COUNT + THB_COUNT + H_PIXEL_COUNT + THF_COUNT;
  localparam int VTOTAL = TVP_COUNT + TVB_COUNT + V_PIXEL_COUNT + TVF_COUNT;
  localparam int HW     = $clog2(HTOTAL);
  localparam int VW     = $clog2(VTOTAL);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int HA0    = THP_COUNT + THB_COUNT;
  localparam int HA1    = HA0 + H_PIXEL_COUNT;
  localparam int VA0    = TVP_COUNT + TVB_COUNT;
  localparam int VA1    = VA0 + V_PIXEL_COUNT;

  typedef enum logic [1:0] {SEEK, FILL, RUN} state_t;

  state_t                  state_q;
  logic [HW-1:0]           h_cnt_q;
  logic [VW-1:0]           v_cnt_q;
  logic [DATA_WIDTH+1:0]   mem [FIFO_DEPTH];
  logic [AW:0]             wr_ptr_q, rd_ptr_q, level;
  logic                    full, empty;
  logic [DATA_WIDTH-1:0]   rd_tdata;
  logic                    rd_tlast, rd_tuser;
  logic                    h_last, v_last, frame_last;
  logic                    hs_act, vs_act, act, first_px, line_last_px;
  logic                    push, run_act, pop, uflow, lerr;
  logic                    tpg_on;
  logic [DATA_WIDTH-1:0]   tpg_dat;

  // raster decode of the free-running counters
  assign h_last       = (h_cnt_q == HW'(HTOTAL - 1));
  assign v_last       = (v_cnt_q == VW'(VTOTAL - 1));
  assign frame_last   = h_last & v_last;
  assign hs_act       = (h_cnt_q < HW'(THP_COUNT));
  assign vs_act       = (v_cnt_q < VW'(TVP_COUNT));
  assign act          = (h_cnt_q >= HW'(HA0)) & (h_cnt_q < HW'(HA1)) &
                        (v_cnt_q >= VW'(VA0)) & (v_cnt_q < VW'(VA1));
  assign first_px     = (h_cnt_q == HW'(HA0)) & (v_cnt_q == VW'(VA0));
  assign line_last_px = (h_cnt_q == HW'(HA1 - 1));

`ifdef LCD_TEST_PATTERN_EN
  logic [HW-1:0] tpg_hpix;
  logic [2:0]    tpg_bar;
  int            tpg_bar_int;
  assign tpg_on = tpg_i;
  // colour bar index from horizontal pixel position, 3-bit index replicated across the pixel
  always_comb begin
    tpg_hpix    = h_cnt_q - HW'(HA0);
    tpg_bar_int = (int'(tpg_hpix) * 8) / H_PIXEL_COUNT;
    tpg_bar     = tpg_bar_int[2:0];
    tpg_dat     = '0;
    for (int i = 0; i < DATA_WIDTH; i++) tpg_dat[i] = tpg_bar[i % 3];
  end
`else
  assign tpg_on  = 1'b0;
  assign tpg_dat = '0;
`endif

  // FIFO status from registered pointers only, so a pop never frees a slot for a same-cycle push
  assign level = wr_ptr_q - rd_ptr_q;
  assign full  = level[AW];
  assign empty = (level == '0);
  assign {rd_tlast, rd_tuser, rd_tdata} = mem[rd_ptr_q[AW-1:0]];

  assign s_axis_tready = rst_ni & ((state_q == SEEK) | ~full);
  // in SEEK only the start-of-frame beat is kept; everything before it is dropped
  assign push    = s_axis_tvalid & s_axis_tready & ~tpg_on & ((state_q != SEEK) | s_axis_tuser);
  assign run_act = (state_q == RUN) & act & ~tpg_on;
  assign pop     = run_act & ~empty;
  assign uflow   = run_act & (empty | (rd_tuser & ~first_px));
  assign lerr    = pop & ~uflow & (rd_tlast != line_last_px);

  // free-running horizontal/vertical counters
  always_ff @(posedge aclk_i) begin
    if (!rst_ni) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else if (h_last) begin
      h_cnt_q <= '0;
      v_cnt_q <= v_last ? '0 : v_cnt_q + 1'b1;
    end else begin
      h_cnt_q <= h_cnt_q + 1'b1;
    end
  end

  // FIFO storage write port
  always_ff @(posedge aclk_i) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= {s_axis_tlast, s_axis_tuser, s_axis_tdata};
  end

  // FIFO pointers; underflow or test pattern discards everything buffered
  always_ff @(posedge aclk_i) begin
    if (!rst_ni || uflow || tpg_on) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // frame-lock FSM with registered lock, sticky flags and frame counter
  always_ff @(posedge aclk_i) begin
    if (!rst_ni) begin
      state_q     <= SEEK;
      locked_o    <= 1'b0;
      underflow_o <= 1'b0;
      line_err_o  <= 1'b0;
      frame_cnt_o <= '0;
    end else begin
      case (state_q)
        SEEK: if (push) state_q <= FILL;
        FILL: if (frame_last && (level >= (AW+1)'(PREFILL))) begin
          state_q  <= RUN;
          locked_o <= 1'b1;
        end
        RUN: if (uflow) begin
          state_q  <= SEEK;
          locked_o <= 1'b0;
        end
        default: begin
          state_q  <= SEEK;
          locked_o <= 1'b0;
        end
      endcase
      if (tpg_on) begin
        state_q  <= SEEK;
        locked_o <= 1'b0;
      end
      if (uflow)      underflow_o <= 1'b1;
      else if (clr_i) underflow_o <= 1'b0;
      if (lerr)       line_err_o  <= 1'b1;
      else if (clr_i) line_err_o  <= 1'b0;
      if ((state_q == RUN) && frame_last && !tpg_on) frame_cnt_o <= frame_cnt_o + 1'b1;
    end
  end

  // LCD pin outputs, one clock behind the counter decode, all four aligned
  always_ff @(posedge aclk_i) begin
    if (!rst_ni) begin
      hsync_o   <= !HSYNC_POL;
      vsync_o   <= !VSYNC_POL;
      enable_o  <= 1'b0;
      lcd_dat_o <= '0;
    end else begin
      hsync_o  <= hs_act ? HSYNC_POL : !HSYNC_POL;
      vsync_o  <= vs_act ? VSYNC_POL : !VSYNC_POL;
      enable_o <= act & ((state_q == RUN) | tpg_on);
      if (tpg_on)             lcd_dat_o <= act ? tpg_dat : '0;
      else if (pop && !uflow) lcd_dat_o <= rd_tdata;
      else                    lcd_dat_o <= '0;
    end
  end

endmodule

// File: tb/tb_lcd_stream_out.sv
// Directed bench for lcd_stream_out at default parameters (HTOTAL=17, VTOTAL=22).
// Raster position k counts clock edges since reset release; outputs sampled on the falling edge.
// Active window: h 5..12 on lines 11..14, i.e. k = frame_base + line*17 + h.
module tb_lcd_stream_out;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [17:0] s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser, clr_i;
  logic        hsync_o, vsync_o, enable_o, locked_o, underflow_o, line_err_o;
  logic [17:0] lcd_dat_o;
  logic [15:0] frame_cnt_o;

  lcd_stream_out dut (
    .aclk_i(clk), .rst_ni(rst_ni),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser), .clr_i(clr_i),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .enable_o(enable_o), .lcd_dat_o(lcd_dat_o),
    .locked_o(locked_o), .underflow_o(underflow_o), .line_err_o(line_err_o),
    .frame_cnt_o(frame_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic last; logic user; logic [17:0] dat; } beat_t;
  typedef struct { int k; logic hs; logic vs; logic en; logic lk; logic [17:0] dat; } vec_t;

  beat_t       src[$];
  logic [17:0] seen[$];
  vec_t        tab[$];
  int          cyc_idx;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // one clock: present the stream head, note acceptance, then land on the next falling edge
  task automatic step();
    s_axis_tvalid = (src.size() > 0);
    if (src.size() > 0) {s_axis_tlast, s_axis_tuser, s_axis_tdata} = src[0];
    else {s_axis_tlast, s_axis_tuser, s_axis_tdata} = '0;
    #1;
    if (s_axis_tvalid && s_axis_tready) void'(src.pop_front());
    @(posedge clk);
    cyc_idx++;
    @(negedge clk);
    if (enable_o) seen.push_back(lcd_dat_o);
  endtask

  task automatic do_reset();
    src.delete();
    seen.delete();
    rst_ni = 1'b0;
    step();
    step();
    chk("reset_pins", 64'({hsync_o, vsync_o, enable_o, locked_o, lcd_dat_o}), 64'({4'b1100, 18'h0}));
    chk("reset_status", 64'({s_axis_tready, underflow_o, line_err_o, frame_cnt_o}), 64'h0);
    rst_ni = 1'b1;
    cyc_idx = -1;
  endtask

  function automatic void add(input int k, input logic hs, input logic vs, input logic en,
                              input logic lk, input logic [17:0] dat);
    vec_t v;
    v.k = k; v.hs = hs; v.vs = vs; v.en = en; v.lk = lk; v.dat = dat;
    tab.push_back(v);
  endfunction

  task automatic run_tab(input string nm);
    foreach (tab[i]) begin
      while (cyc_idx < tab[i].k) step();
      chk($sformatf("%s@%0d", nm, tab[i].k),
          64'({hsync_o, vsync_o, enable_o, locked_o, lcd_dat_o}),
          64'({tab[i].hs, tab[i].vs, tab[i].en, tab[i].lk, tab[i].dat}));
    end
    tab.delete();
  endtask

  // frame of n pixels: data 0x100+i, tuser on pixel 0, tlast on every 8th (or at bad_last instead of bad_last+1)
  task automatic load_frame(input int n, input int bad_last);
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.dat  = 18'h100 + 18'(i);
      b.user = (i == 0);
      b.last = (i % 8 == 7);
      if (i == bad_last)     b.last = 1'b1;
      if (i == bad_last + 1) b.last = 1'b0;
      src.push_back(b);
    end
  endtask

  task automatic stream_frame_test(input string nm, input int junk);
    logic ok;
    do_reset();
    for (int i = 0; i < junk; i++) src.push_back({1'b0, 1'b0, 18'h3AA});
    load_frame(32, -10);
    add(0,   0, 0, 0, 0, 18'h0);
    add(372, 1, 1, 0, 0, 18'h0);
    add(373, 1, 1, 0, 1, 18'h0);
    add(565, 1, 1, 0, 1, 18'h0);
    add(566, 1, 1, 1, 1, 18'h100);
    add(573, 1, 1, 1, 1, 18'h107);
    add(574, 1, 1, 0, 1, 18'h0);
    add(583, 1, 1, 1, 1, 18'h108);
    add(624, 1, 1, 1, 1, 18'h11F);
    add(625, 1, 1, 0, 1, 18'h0);
    run_tab(nm);
    while (cyc_idx < 746) step();
    chk({nm, "_fcnt_before"}, 64'(frame_cnt_o), 64'd0);
    step();
    chk({nm, "_fcnt_after"}, 64'(frame_cnt_o), 64'd1);
    chk({nm, "_flags"}, 64'({underflow_o, line_err_o}), 64'd0);
    chk({nm, "_nseen"}, 64'(seen.size()), 64'd32);
    ok = (seen.size() == 32);
    foreach (seen[i]) if (seen[i] !== 18'h100 + 18'(i)) ok = 1'b0;
    chk({nm, "_order"}, 64'(ok), 64'd1);
  endtask

  initial begin
    rst_ni = 1'b0; clr_i = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
    cyc_idx = -1;
    @(negedge clk);

    // idle raster, no stream
    do_reset();
    add(0,   0, 0, 0, 0, 18'h0);
    add(1,   0, 0, 0, 0, 18'h0);
    add(2,   1, 0, 0, 0, 18'h0);
    add(16,  1, 0, 0, 0, 18'h0);
    add(17,  0, 0, 0, 0, 18'h0);
    add(84,  1, 0, 0, 0, 18'h0);
    add(85,  0, 1, 0, 0, 18'h0);
    add(87,  1, 1, 0, 0, 18'h0);
    add(373, 1, 1, 0, 0, 18'h0);
    add(374, 0, 0, 0, 0, 18'h0);
    add(458, 1, 0, 0, 0, 18'h0);
    add(459, 0, 1, 0, 0, 18'h0);
    add(566, 1, 1, 0, 0, 18'h0);
    run_tab("idle");
    chk("idle_tready", 64'(s_axis_tready), 64'd1);

    // clean frame, then the same frame preceded by junk beats
    stream_frame_test("frame", 0);
    stream_frame_test("junk", 5);

    // underflow after 20 pixels, relock on the next full frame, clear sticky flag
    do_reset();
    load_frame(20, -10);
    add(373, 1, 1, 0, 1, 18'h0);
    add(603, 1, 1, 1, 1, 18'h113);
    run_tab("uflow");
    chk("uflow_flag_before", 64'(underflow_o), 64'd0);
    step();
    chk("uflow_pixel", 64'({enable_o, locked_o, underflow_o, lcd_dat_o}), 64'({3'b101, 18'h0}));
    step();
    chk("uflow_after", 64'({enable_o, locked_o}), 64'd0);
    load_frame(32, -10);
    while (cyc_idx < 746) step();
    chk("relock_before", 64'(locked_o), 64'd0);
    step();
    chk("relock", 64'({locked_o, frame_cnt_o}), 64'({1'b1, 16'd0}));
    while (cyc_idx < 940) step();
    chk("relock_pix0", 64'({enable_o, underflow_o, lcd_dat_o}), 64'({2'b11, 18'h100}));
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    chk("clr_uflow", 64'({enable_o, underflow_o, lcd_dat_o}), 64'({2'b10, 18'h101}));

    // tlast on pixel 6 instead of 7
    do_reset();
    load_frame(32, 6);
    while (cyc_idx < 571) step();
    chk("lerr_before", 64'(line_err_o), 64'd0);
    step();
    chk("lerr_set", 64'({line_err_o, locked_o, lcd_dat_o}), 64'({2'b11, 18'h106}));
    while (cyc_idx < 747) step();
    chk("lerr_still_locked", 64'({locked_o, line_err_o, frame_cnt_o}), 64'({2'b11, 16'd1}));

    // one-clock reset mid-line
    while (cyc_idx < 760) step();
    rst_ni = 1'b0;
    step();
    chk("midrst_pins", 64'({hsync_o, vsync_o, enable_o, locked_o, lcd_dat_o}), 64'({4'b1100, 18'h0}));
    chk("midrst_status", 64'({s_axis_tready, underflow_o, line_err_o, frame_cnt_o}), 64'h0);
    rst_ni = 1'b1;
    cyc_idx = -1;
    add(0, 0, 0, 0, 0, 18'h0);
    add(1, 0, 0, 0, 0, 18'h0);
    add(2, 1, 0, 0, 0, 18'h0);
    run_tab("midrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
